mux_scan_nx1: RTL and testbench

//  Parametrised N-to-1 multiplexer, W bits per channel, with a registered output. Two

---
 rtl/mux_scan_nx1_pkg.sv | 13 +
 rtl/mux_scan_nx1_tick_prescaler.sv | 37 +++
 rtl/mux_scan_nx1.sv | 115 +++++++++++
 tb/tb_mux_scan_nx1.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/mux_scan_nx1_pkg.sv
// Shared encodings for the scanning N-to-1 multiplexer and its helpers.
package mux_scan_nx1_pkg;

  localparam logic MODE_MAN  = 1'b0;
  localparam logic MODE_SCAN = 1'b1;

  typedef enum logic [1:0] {
    ST_MAN  = 2'd0,
    ST_SCAN = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/mux_scan_nx1_tick_prescaler.sv
// Dwell prescaler: counts enabled cycles and pulses tick on the last one of every DWELL.
module tick_prescaler #(
  parameter int DWELL = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(DWELL) + 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == LAST);

  // Disabled cycles freeze the count so a paused scan resumes mid-dwell.
  always_comb begin
    cnt_d = cnt_q;
    if (clr || tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mux_scan_nx1.sv
// N-to-1 registered multiplexer with manual select and auto-scan (dwell, hold, wrap pulse).
module mux_scan_nx1
  import mux_scan_nx1_pkg::*;
#(
  parameter int W     = 4,
  parameter int N     = 8,
  parameter int SELW  = $clog2(N),
  parameter int DWELL = 50000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N*W-1:0]  i_bus,
  input  logic [SELW-1:0] s,
  input  logic            mode,
  input  logic            hold,
  output logic [W-1:0]    f,
  output logic [SELW-1:0] sel_out,
  output logic [N-1:0]    onehot,
  output logic            wrap
);

  localparam logic [SELW:0]   NUM  = (SELW + 1)'(N);
  localparam logic [SELW-1:0] LAST = SELW'(N - 1);

  state_e          state_q, state_d;
  logic [SELW-1:0] ch_q, ch_d;
  logic [W-1:0]    f_q, f_d;
  logic [N-1:0]    onehot_q, onehot_d;
  logic            wrap_q, wrap_d;
  logic            s_ok, ch_ok, tick, scan_en, scan_clr;

  assign s_ok     = ({1'b0, s} < NUM);
  assign scan_en  = (state_q == ST_SCAN) && (mode == MODE_SCAN) && !hold;
  assign scan_clr = (state_q == ST_MAN);

  tick_prescaler #(.DWELL(DWELL)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (scan_en),
    .clr   (scan_clr),
    .tick  (tick)
  );

  // Hold takes priority over a terminal dwell, so a held scan never steps or wraps.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    case (state_q)
      ST_MAN: begin
        if (mode == MODE_SCAN) begin
          state_d = ST_SCAN;
          ch_d    = s_ok ? s : '0;
        end else begin
          ch_d = s;
        end
      end
      ST_SCAN: begin
        if (mode == MODE_MAN) begin
          state_d = ST_MAN;
          ch_d    = s;
        end else if (hold) begin
          state_d = ST_HOLD;
        end else if (tick) begin
          ch_d = (ch_q == LAST) ? '0 : ch_q + SELW'(1);
        end
      end
      ST_HOLD: begin
        if (mode == MODE_MAN) begin
          state_d = ST_MAN;
          ch_d    = s;
        end else if (!hold) begin
          state_d = ST_SCAN;
        end
      end
      default: begin
        state_d = ST_MAN;
        ch_d    = '0;
      end
    endcase
  end

  // Outputs are computed from the channel being registered, so they move together with ch.
  always_comb begin
    ch_ok    = ({1'b0, ch_d} < NUM);
    f_d      = '0;
    onehot_d = '0;
    if (ch_ok) begin
      f_d            = i_bus[int'(ch_d)*W +: W];
      onehot_d[ch_d] = 1'b1;
    end
    wrap_d = tick && (ch_q == LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_MAN;
      ch_q     <= '0;
      f_q      <= '0;
      onehot_q <= '0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      f_q      <= f_d;
      onehot_q <= onehot_d;
      wrap_q   <= wrap_d;
    end
  end

  assign f       = f_q;
  assign sel_out = ch_q;
  assign onehot  = onehot_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_mux_scan_nx1.sv
// Directed bench: three mux_scan_nx1 instances (N=8/DWELL=4, N=6/DWELL=4, N=8/DWELL=1).
module tb_mux_scan_nx1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Instance A: N=8, W=4, DWELL=4
  logic        rstA, modeA, holdA, wrapA;
  logic [31:0] busA;
  logic [2:0]  sA, selA;
  logic [3:0]  fA;
  logic [7:0]  ohA;

  // Instance B: N=6, W=4, SELW=3, DWELL=4
  logic        rstB, modeB, holdB, wrapB;
  logic [23:0] busB;
  logic [2:0]  sB, selB;
  logic [3:0]  fB;
  logic [5:0]  ohB;

  // Instance C: N=8, W=4, DWELL=1
  logic        rstC, modeC, holdC, wrapC;
  logic [31:0] busC;
  logic [2:0]  sC, selC;
  logic [3:0]  fC;
  logic [7:0]  ohC;

  mux_scan_nx1 #(.W(4), .N(8), .SELW(3), .DWELL(4)) dutA (
    .clk(clk), .rst_n(rstA), .i_bus(busA), .s(sA), .mode(modeA), .hold(holdA),
    .f(fA), .sel_out(selA), .onehot(ohA), .wrap(wrapA));

  mux_scan_nx1 #(.W(4), .N(6), .SELW(3), .DWELL(4)) dutB (
    .clk(clk), .rst_n(rstB), .i_bus(busB), .s(sB), .mode(modeB), .hold(holdB),
    .f(fB), .sel_out(selB), .onehot(ohB), .wrap(wrapB));

  mux_scan_nx1 #(.W(4), .N(8), .SELW(3), .DWELL(1)) dutC (
    .clk(clk), .rst_n(rstC), .i_bus(busC), .s(sC), .mode(modeC), .hold(holdC),
    .f(fC), .sel_out(selC), .onehot(ohC), .wrap(wrapC));

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstA = 1'b0; rstB = 1'b0; rstC = 1'b0;
    modeA = 1'b0; modeB = 1'b0; modeC = 1'b0;
    holdA = 1'b0; holdB = 1'b0; holdC = 1'b0;
    sA = '0; sB = '0; sC = '0;
    busA = '0; busB = '0; busC = '0;
    for (int k = 0; k < 8; k++) begin
      busA[k*4 +: 4] = 4'(k + 3);
      busC[k*4 +: 4] = 4'(k + 3);
    end
    for (int k = 0; k < 6; k++) busB[k*4 +: 4] = 4'(k + 3);

    #12;
    checkOutput("rst f",      32'(fA),    32'd0);
    checkOutput("rst sel",    32'(selA),  32'd0);
    checkOutput("rst onehot", 32'(ohA),   32'd0);
    checkOutput("rst wrap",   32'(wrapA), 32'd0);
    checkOutput("rstB f",     32'(fB),    32'd0);
    checkOutput("rstC sel",   32'(selC),  32'd0);
    rstA = 1'b1; rstB = 1'b1; rstC = 1'b1;

    // Manual select
    sA = 3'd5;
    applyStimulus();
    checkOutput("man f",      32'(fA),    32'd8);
    checkOutput("man sel",    32'(selA),  32'd5);
    checkOutput("man onehot", 32'(ohA),   32'h20);
    checkOutput("man wrap",   32'(wrapA), 32'd0);

    // Scan from 6 with DWELL=4
    sA = 3'd6; modeA = 1'b1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus();
      checkOutput($sformatf("scan sel %0d", i), 32'(selA),
                  (i < 4) ? 32'd6 : (i < 8) ? 32'd7 : 32'd0);
      checkOutput($sformatf("scan wrap %0d", i), 32'(wrapA), (i == 8) ? 32'd1 : 32'd0);
    end
    checkOutput("scan f ch0",  32'(fA),  32'd3);
    checkOutput("scan onehot", 32'(ohA), 32'h01);

    // Dwell now 1; two more edges reach the terminal dwell, then hold on that cycle
    applyStimulus();
    applyStimulus();
    checkOutput("pre-hold sel", 32'(selA), 32'd0);
    holdA = 1'b1;
    applyStimulus();
    checkOutput("hold sel",  32'(selA),  32'd0);
    checkOutput("hold wrap", 32'(wrapA), 32'd0);
    busA[3:0] = 4'd9;
    applyStimulus();
    checkOutput("hold f live", 32'(fA),   32'd9);
    checkOutput("hold sel2",   32'(selA), 32'd0);
    applyStimulus();
    checkOutput("hold sel3", 32'(selA), 32'd0);
    holdA = 1'b0;
    applyStimulus();
    checkOutput("release sel", 32'(selA), 32'd0);
    applyStimulus();
    checkOutput("resume step sel", 32'(selA), 32'd1);
    checkOutput("resume step f",   32'(fA),   32'd4);
    checkOutput("resume wrap",     32'(wrapA), 32'd0);
    modeA = 1'b0; sA = 3'd2;
    applyStimulus();
    checkOutput("back man sel", 32'(selA), 32'd2);
    checkOutput("back man f",   32'(fA),   32'd5);

    // Out of range select on N=6
    sB = 3'd7;
    applyStimulus();
    checkOutput("oor f",      32'(fB),   32'd0);
    checkOutput("oor onehot", 32'(ohB),  32'd0);
    checkOutput("oor sel",    32'(selB), 32'd7);
    modeB = 1'b1;
    applyStimulus();
    checkOutput("oor scan sel",    32'(selB), 32'd0);
    checkOutput("oor scan f",      32'(fB),   32'd3);
    checkOutput("oor scan onehot", 32'(ohB),  32'h01);
    holdB = 1'b1;
    applyStimulus();
    checkOutput("hold in scan B", 32'(selB), 32'd0);

    // DWELL=1 continuous scan
    modeC = 1'b1; sC = 3'd0;
    for (int i = 0; i < 17; i++) begin
      applyStimulus();
      checkOutput($sformatf("d1 sel %0d", i), 32'(selC), 32'(i % 8));
      checkOutput($sformatf("d1 wrap %0d", i), 32'(wrapC),
                  (i == 8 || i == 16) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 4; i++) applyStimulus();
    checkOutput("pre-reset sel", 32'(selC), 32'd4);
    checkOutput("pre-reset f",   32'(fC),   32'd7);

    // Asynchronous reset mid-scan, sampled before the next edge
    #2;
    rstC = 1'b0;
    #1;
    checkOutput("async rst sel",    32'(selC),  32'd0);
    checkOutput("async rst f",      32'(fC),    32'd0);
    checkOutput("async rst onehot", 32'(ohC),   32'd0);
    checkOutput("async rst wrap",   32'(wrapC), 32'd0);
    modeC = 1'b0; sC = 3'd3;
    #1;
    rstC = 1'b1;
    applyStimulus();
    checkOutput("post rst sel",    32'(selC), 32'd3);
    checkOutput("post rst f",      32'(fC),   32'd6);
    checkOutput("post rst onehot", 32'(ohC),  32'h08);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
